mmu_host_loader: RTL

Hardware host front-end for the matrix-multiply subsystem, and the parametrised successor to the hand-written load/start sequence used to drive the multiplier chain. It accepts matrix elements on a valid/ready stream, packs them into N-element rows, and writes them into the user ports of matrix memories A and B. It then pulses `start` to the DMA controller, counts C-memory writes to detect completion, and streams the C result back out element by element. It sits between a system bus/stream master and the user side of the matrix BRAM.

---
 rtl/mmu_host_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mmu_host_loader.sv
// mmu_host_loader: host front-end for the matrix-multiply subsystem.
// Packs A/B rows into BRAM, kicks the DMA, then streams C back out.
module mmu_host_loader #(
  parameter int N = 6,
  parameter int WIDTH = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1,
  parameter int ADDR = $clog2(N),
  parameter int START_CYC = 3,
  parameter int RD_LAT = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_start,
  input  logic                   cmd_keep_b,
  output logic                   busy,
  output logic                   err,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   A_USR_wr,
  output logic                   B_USR_wr,
  output logic [ADDR-1:0]        A_USR_addr,
  output logic [ADDR-1:0]        B_USR_addr,
  output logic [N*WIDTH-1:0]     A_USR_din,
  output logic [N*WIDTH-1:0]     B_USR_din,
  output logic                   start,
  input  logic                   C_MAT_wr,
  output logic                   C_USR_rd,
  output logic [ADDR-1:0]        C_USR_addr,
  input  logic [N*M_WIDTH-1:0]   C_USR_dout,
  output logic [M_WIDTH-1:0]     m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready
);
  localparam int CW = $clog2(N+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int KW = $clog2(START_CYC+1);
  localparam int RW = $clog2(RD_LAT+1);
  localparam logic [ADDR-1:0] LAST = ADDR'(N-1);
  localparam logic [CW-1:0] NCNT = CW'(N);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT-1);
  localparam logic [KW-1:0] KLAST = KW'(START_CYC-1);
  localparam logic [RW-1:0] RLAST = RW'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, KICK, WAIT, READ, DRAIN
  } state_t;

  state_t state, nxt;

  logic [ADDR-1:0]      col, row, rrow, elem;
  logic [N*WIDTH-1:0]   pack, full_row;
  logic [N*M_WIDTH-1:0] rbuf;
  logic [CW-1:0]        ccnt;
  logic [TW-1:0]        tcnt;
  logic [KW-1:0]        kcnt;
  logic [RW-1:0]        rcnt;
  logic keep_b, flush;
  logic beat, row_end, mat_end, go_flush, hs, latch;

  assign beat     = s_valid & s_ready;
  assign row_end  = beat & (col == LAST);
  assign mat_end  = row_end & (row == LAST);
  // The last write of a load needs one idle cycle before KICK
  assign go_flush = mat_end & ((state == LOAD_B) | keep_b);
  assign hs       = m_valid & m_ready;
  assign latch    = (state == READ) & (rcnt == RLAST);

  always_comb begin
    full_row = pack;
    full_row[(N-1)*WIDTH +: WIDTH] = s_data;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (cmd_start) nxt = LOAD_A;
      LOAD_A: if (flush) nxt = KICK;
              else if (mat_end && !keep_b) nxt = LOAD_B;
      LOAD_B: if (flush) nxt = KICK;
      KICK:   if (kcnt == KLAST) nxt = WAIT;
      WAIT:   if (ccnt == NCNT) nxt = READ;
              else if (tcnt == TLAST) nxt = IDLE;
      READ:   if (latch) nxt = DRAIN;
      DRAIN:  if (hs && elem == LAST)
                nxt = (rrow == LAST) ? IDLE : READ;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; err <= 1'b0; s_ready <= 1'b0;
      A_USR_wr <= 1'b0; B_USR_wr <= 1'b0;
      A_USR_addr <= '0; B_USR_addr <= '0;
      A_USR_din <= '0; B_USR_din <= '0;
      start <= 1'b0; C_USR_rd <= 1'b0; C_USR_addr <= '0;
      m_data <= '0; m_valid <= 1'b0; m_last <= 1'b0;
      col <= '0; row <= '0; rrow <= '0; elem <= '0;
      pack <= '0; rbuf <= '0;
      ccnt <= '0; tcnt <= '0; kcnt <= '0; rcnt <= '0;
      keep_b <= 1'b0; flush <= 1'b0;
    end else begin
      busy     <= (nxt != IDLE);
      s_ready  <= ((nxt == LOAD_A) | (nxt == LOAD_B)) & ~go_flush;
      start    <= (nxt == KICK);
      flush    <= go_flush;
      A_USR_wr <= row_end & (state == LOAD_A);
      B_USR_wr <= row_end & (state == LOAD_B);
      C_USR_rd <= (nxt == READ) & (state != READ);

      if (state == IDLE && cmd_start) begin
        keep_b <= cmd_keep_b;
        err    <= 1'b0;
        col    <= '0;
        row    <= '0;
      end
      if (beat) begin
        pack[col*WIDTH +: WIDTH] <= s_data;
        col <= (col == LAST) ? '0 : col + 1'b1;
        if (col == LAST)
          row <= (row == LAST) ? '0 : row + 1'b1;
      end
      if (row_end && state == LOAD_A) begin
        A_USR_din  <= full_row;
        A_USR_addr <= row;
      end
      if (row_end && state == LOAD_B) begin
        B_USR_din  <= full_row;
        B_USR_addr <= row;
      end

      kcnt <= (state == KICK) ? kcnt + 1'b1 : '0;
      // C writes may already arrive while start is still high
      if (state != KICK && nxt == KICK)
        ccnt <= '0;
      else if ((state == KICK || state == WAIT) && C_MAT_wr && ccnt != NCNT)
        ccnt <= ccnt + 1'b1;
      tcnt <= (state == WAIT) ? tcnt + 1'b1 : '0;
      if (state == WAIT && nxt == IDLE) err <= 1'b1;

      rcnt <= (state == READ) ? rcnt + 1'b1 : '0;
      if (state == WAIT) rrow <= '0;
      if (nxt == READ && state != READ)
        C_USR_addr <= (state == DRAIN) ? rrow + 1'b1 : '0;

      if (latch) begin
        rbuf    <= C_USR_dout;
        elem    <= '0;
        m_data  <= C_USR_dout[M_WIDTH-1:0];
        m_valid <= 1'b1;
        m_last  <= (rrow == LAST) && (N == 1);
      end else if (state == DRAIN && hs) begin
        if (elem == LAST) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          if (rrow != LAST) rrow <= rrow + 1'b1;
        end else begin
          elem   <= elem + 1'b1;
          m_data <= rbuf[(elem+1)*M_WIDTH +: M_WIDTH];
          m_last <= (rrow == LAST) && (elem + 1'b1 == LAST);
        end
      end
    end
  end
endmodule
